crc_job_initiator: RTL and testbench

CRC_JOB_INITIATOR -- requirements
Module: crc_job_initiator

---
 rtl/crc_job_initiator_if.sv | 46 ++++
 rtl/crc_job_initiator.sv | 232 +++++++++++++++++++++++
 tb/tb_crc_job_initiator.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_job_initiator_if.sv
// Signal bundle between the CRC job initiator and its environment: job request,
// input-word stream, CRC register bus and result handshake.
interface crc_job_initiator_if #(
    parameter int WORD_SIZE = 32
);
    logic                 job_start;
    logic [31:0]          job_config;
    logic [7:0]           job_len;
    logic                 job_busy;

    logic [31:0]          din;
    logic                 din_valid;
    logic                 din_ready;

    logic                 bus_req;
    logic                 bus_wen;
    logic [WORD_SIZE-1:0] bus_addr;
    logic [WORD_SIZE-1:0] bus_wdata;
    logic [WORD_SIZE-1:0] bus_rdata;
    logic                 bus_ready;

    logic [31:0]          result;
    logic                 result_err;
    logic                 result_valid;
    logic                 result_ready;

    modport master (
        input  job_start, job_config, job_len,
        input  din, din_valid,
        input  bus_rdata, bus_ready,
        input  result_ready,
        output job_busy, din_ready,
        output bus_req, bus_wen, bus_addr, bus_wdata,
        output result, result_err, result_valid
    );

    modport slave (
        output job_start, job_config, job_len,
        output din, din_valid,
        output bus_rdata, bus_ready,
        output result_ready,
        input  job_busy, din_ready,
        input  bus_req, bus_wen, bus_addr, bus_wdata,
        input  result, result_err, result_valid
    );
endinterface

// File: rtl/crc_job_initiator.sv
// CRC job initiator: programs the CRC peripheral, streams input words, polls status and
// returns the output. Define POLI_CRC_TIMEOUT_EN to bound polling to POLL_MAX status reads.
// States: IDLE | WR_CFG, WR_CTRL setup writes | GET_DIN, WR_DIN word stream | POLL | RD_OUT | RESULT
module crc_job_initiator #(
    parameter int          WORD_SIZE = 32,
    parameter logic [31:0] BASE_ADDR = 32'h00ff0000,
    parameter int          POLL_MAX  = 1000
) (
    input logic                 CLK,
    input logic                 nRST,
    crc_job_initiator_if.master ctl
);
    localparam logic [WORD_SIZE-1:0] ADDR_CONTROL = WORD_SIZE'(BASE_ADDR + 32'h18);
    localparam logic [WORD_SIZE-1:0] ADDR_CONFIG  = WORD_SIZE'(BASE_ADDR + 32'h1C);
    localparam logic [WORD_SIZE-1:0] ADDR_STATUS  = WORD_SIZE'(BASE_ADDR + 32'h20);
    localparam logic [WORD_SIZE-1:0] ADDR_INPUT   = WORD_SIZE'(BASE_ADDR + 32'h24);
    localparam logic [WORD_SIZE-1:0] ADDR_OUTPUT  = WORD_SIZE'(BASE_ADDR + 32'h28);

    typedef enum logic [2:0] {
        IDLE,
        WR_CFG,
        WR_CTRL,
        GET_DIN,
        WR_DIN,
        POLL,
        RD_OUT,
        RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          cfg_q, cfg_d;
    logic [7:0]           len_q, len_d;
    logic [31:0]          word_q, word_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_wen_q, bus_wen_d;
    logic [WORD_SIZE-1:0] bus_addr_q, bus_addr_d;
    logic [WORD_SIZE-1:0] bus_wdata_q, bus_wdata_d;
    logic                 din_ready_q, din_ready_d;
    logic                 job_busy_q, job_busy_d;
    logic [31:0]          result_q, result_d;
    logic                 result_err_q, result_err_d;
    logic                 result_valid_q, result_valid_d;
`ifdef POLI_CRC_TIMEOUT_EN
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
    logic [15:0]          poll_cnt_q, poll_cnt_d;
`endif

    // Each bus state raises the request from an idle bus and drops it on completion,
    // so consecutive accesses are always separated by at least one low cycle.
    always_comb begin
        state_d        = state_q;
        cfg_d          = cfg_q;
        len_d          = len_q;
        word_d         = word_q;
        bus_req_d      = bus_req_q;
        bus_wen_d      = bus_wen_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        din_ready_d    = din_ready_q;
        result_d       = result_q;
        result_err_d   = result_err_q;
        result_valid_d = result_valid_q;
`ifdef POLI_CRC_TIMEOUT_EN
        poll_cnt_d     = poll_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (ctl.job_start) begin
                    cfg_d   = ctl.job_config;
                    len_d   = ctl.job_len;
                    state_d = WR_CFG;
`ifdef POLI_CRC_TIMEOUT_EN
                    poll_cnt_d = POLL_LIMIT;
`endif
                end
            end

            WR_CFG: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_wen_d   = 1'b1;
                    bus_addr_d  = ADDR_CONFIG;
                    bus_wdata_d = WORD_SIZE'(cfg_q);
                end else if (ctl.bus_ready) begin
                    bus_req_d = 1'b0;
                    state_d   = WR_CTRL;
                end
            end

            WR_CTRL: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_wen_d   = 1'b1;
                    bus_addr_d  = ADDR_CONTROL;
                    bus_wdata_d = WORD_SIZE'(32'h1);
                end else if (ctl.bus_ready) begin
                    bus_req_d = 1'b0;
                    if (len_q != 8'd0) begin
                        state_d     = GET_DIN;
                        din_ready_d = 1'b1;
                    end else begin
                        state_d = POLL;
                    end
                end
            end

            GET_DIN: begin
                if (ctl.din_valid && din_ready_q) begin
                    word_d      = ctl.din;
                    din_ready_d = 1'b0;
                    state_d     = WR_DIN;
                end
            end

            WR_DIN: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_wen_d   = 1'b1;
                    bus_addr_d  = ADDR_INPUT;
                    bus_wdata_d = WORD_SIZE'(word_q);
                end else if (ctl.bus_ready) begin
                    bus_req_d = 1'b0;
                    len_d     = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = POLL;
                    end else begin
                        state_d     = GET_DIN;
                        din_ready_d = 1'b1;
                    end
                end
            end

            POLL: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_wen_d   = 1'b0;
                    bus_addr_d  = ADDR_STATUS;
                    bus_wdata_d = '0;
                end else if (ctl.bus_ready) begin
                    bus_req_d = 1'b0;
                    if (!ctl.bus_rdata[0]) begin
                        state_d = RD_OUT;
`ifdef POLI_CRC_TIMEOUT_EN
                    end else if (poll_cnt_q <= 16'd1) begin
                        state_d        = RESULT;
                        result_d       = 32'hDEAD_BEEF;
                        result_err_d   = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q - 16'd1;
`endif
                    end
                end
            end

            RD_OUT: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_wen_d   = 1'b0;
                    bus_addr_d  = ADDR_OUTPUT;
                    bus_wdata_d = '0;
                end else if (ctl.bus_ready) begin
                    bus_req_d      = 1'b0;
                    result_d       = 32'(ctl.bus_rdata);
                    result_err_d   = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = RESULT;
                end
            end

            RESULT: begin
                if (ctl.result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        job_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            cfg_q          <= '0;
            len_q          <= '0;
            word_q         <= '0;
            bus_req_q      <= 1'b0;
            bus_wen_q      <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            din_ready_q    <= 1'b0;
            job_busy_q     <= 1'b0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef POLI_CRC_TIMEOUT_EN
            poll_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cfg_q          <= cfg_d;
            len_q          <= len_d;
            word_q         <= word_d;
            bus_req_q      <= bus_req_d;
            bus_wen_q      <= bus_wen_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            din_ready_q    <= din_ready_d;
            job_busy_q     <= job_busy_d;
            result_q       <= result_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
`ifdef POLI_CRC_TIMEOUT_EN
            poll_cnt_q     <= poll_cnt_d;
`endif
        end
    end

    assign ctl.job_busy     = job_busy_q;
    assign ctl.din_ready    = din_ready_q;
    assign ctl.bus_req      = bus_req_q;
    assign ctl.bus_wen      = bus_wen_q;
    assign ctl.bus_addr     = bus_addr_q;
    assign ctl.bus_wdata    = bus_wdata_q;
    assign ctl.result       = result_q;
    assign ctl.result_err   = result_err_q;
    assign ctl.result_valid = result_valid_q;
endmodule

// File: tb/tb_crc_job_initiator.sv
// Randomized bench for crc_job_initiator: a bus responder and din source checked
// against a per-job expected transaction list built from the job parameters.
module tb_crc_job_initiator;
    localparam int          WS   = 32;
    localparam logic [31:0] BASE = 32'h00ff0000;
`ifdef POLI_CRC_TIMEOUT_EN
    localparam int PM     = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int PM     = 1000;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [31:0] A_CTRL = BASE + 32'h18;
    localparam logic [31:0] A_CFG  = BASE + 32'h1C;
    localparam logic [31:0] A_STAT = BASE + 32'h20;
    localparam logic [31:0] A_IN   = BASE + 32'h24;
    localparam logic [31:0] A_OUT  = BASE + 32'h28;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    crc_job_initiator_if #(.WORD_SIZE(WS)) ifc ();

    crc_job_initiator #(.WORD_SIZE(WS), .BASE_ADDR(BASE), .POLL_MAX(PM)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .ctl (ifc)
    );

    int n_chk = 0;
    int n_pass = 0;

    txn_t        exp_q[$];
    txn_t        trace[$];
    logic [31:0] din_q[$];
    logic [31:0] next_words[$];

    int          busy_left = 0;
    logic [31:0] out_val = 32'h0;
    int          wait_max = 0;
    bit          wait_rand = 1'b0;
    int          din_gap = 0;
    bit          din_gap_rand = 1'b0;
    bit          spurious = 1'b0;
    int          n_status = 0, n_output = 0, n_input = 0;
    int          n_din_xfer = 0, n_din_ready_cyc = 0;
    logic [31:0] exp_res = 32'h0;
    bit          exp_err = 1'b0;
    int          exp_len = 0;
    logic [31:0] last_result = 32'h0;
    logic        last_err = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Bus responder: programmable wait states, busy status for busy_left reads.
    initial begin
        logic        in_prog;
        int          w_left;
        txn_t        held;
        txn_t        e;
        logic [31:0] r;
        in_prog = 1'b0;
        w_left  = 0;
        held    = '0;
        ifc.bus_ready = 1'b0;
        ifc.bus_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                ifc.bus_ready = 1'b0;
                in_prog = 1'b0;
                continue;
            end
            if (ifc.bus_ready) begin
                ifc.bus_ready = 1'b0;
                chk(ifc.bus_req == 1'b0, "bus_req_gap", 32'(ifc.bus_req), 32'h0);
            end else if (ifc.bus_req) begin
                if (!in_prog) begin
                    in_prog = 1'b1;
                    held = '{ifc.bus_wen, ifc.bus_addr, ifc.bus_wdata};
                    w_left = wait_rand ? int'($urandom_range(0, wait_max)) : wait_max;
                end else begin
                    chk(held == {ifc.bus_wen, ifc.bus_addr, ifc.bus_wdata}, "bus_stable",
                        ifc.bus_addr ^ ifc.bus_wdata, held.addr ^ held.data);
                end
                if (w_left == 0) begin
                    in_prog = 1'b0;
                    ifc.bus_ready = 1'b1;
                    if (!ifc.bus_wen && ifc.bus_addr == A_STAT) begin
                        r = $urandom;
                        r[0] = (busy_left > 0);
                        if (busy_left > 0) busy_left--;
                        n_status++;
                    end else if (!ifc.bus_wen && ifc.bus_addr == A_OUT) begin
                        r = out_val;
                        n_output++;
                    end else begin
                        r = $urandom;
                        if (ifc.bus_wen && ifc.bus_addr == A_IN) n_input++;
                    end
                    ifc.bus_rdata = r;
                    trace.push_back('{ifc.bus_wen, ifc.bus_addr, ifc.bus_wen ? ifc.bus_wdata : 32'h0});
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "bus_unexpected", ifc.bus_addr, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(ifc.bus_wen == e.wen && ifc.bus_addr == e.addr &&
                            (!e.wen || ifc.bus_wdata == e.data), "bus_txn",
                            ifc.bus_wen ? ifc.bus_wdata : ifc.bus_addr, e.wen ? e.data : e.addr);
                    end
                end else begin
                    w_left--;
                end
            end else if (spurious) begin
                ifc.bus_ready = 1'b1;
            end
        end
    end

    // Input-word source with programmable gaps after each transfer.
    initial begin
        bit pend;
        int gap;
        pend = 1'b0;
        gap  = 0;
        ifc.din_valid = 1'b0;
        ifc.din = 32'h0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                ifc.din_valid = 1'b0;
                pend = 1'b0;
                gap = 0;
                continue;
            end
            if (pend) begin
                if (din_q.size() > 0) void'(din_q.pop_front());
                n_din_xfer++;
                gap = din_gap_rand ? int'($urandom_range(0, din_gap)) : din_gap;
            end
            if (ifc.din_ready) n_din_ready_cyc++;
            if (gap > 0) begin
                gap--;
                ifc.din_valid = 1'b0;
            end else if (din_q.size() > 0) begin
                ifc.din_valid = 1'b1;
                ifc.din = din_q[0];
            end else begin
                ifc.din_valid = 1'b0;
            end
            pend = ifc.din_valid && ifc.din_ready;
        end
    end

    // Per-cycle consistency: any activity implies busy; never stream and bus at once.
    initial forever begin
        @(negedge CLK);
        if (nRST && (ifc.bus_req || ifc.din_ready || ifc.result_valid))
            chk(ifc.job_busy == 1'b1, "busy_active", 32'(ifc.job_busy), 32'h1);
        if (nRST && ifc.din_ready)
            chk(ifc.bus_req == 1'b0, "din_vs_bus", 32'(ifc.bus_req), 32'h0);
    end

    task automatic start_job(input logic [31:0] cfg, input int len, input int busy,
                             input int waits, input bit wrand, input int gap, input bit grand,
                             input logic [31:0] ov);
        logic [31:0] w;
        bit          tmo;
        int          nstat;
        exp_q.delete();
        din_q.delete();
        trace.delete();
        exp_q.push_back('{1'b1, A_CFG, cfg});
        exp_q.push_back('{1'b1, A_CTRL, 32'h1});
        for (int i = 0; i < len; i++) begin
            if (next_words.size() > 0) w = next_words.pop_front();
            else w = $urandom;
            din_q.push_back(w);
            exp_q.push_back('{1'b1, A_IN, w});
        end
        tmo   = TMO_EN && (busy >= PM);
        nstat = tmo ? PM : busy + 1;
        for (int i = 0; i < nstat; i++) exp_q.push_back('{1'b0, A_STAT, 32'h0});
        if (!tmo) exp_q.push_back('{1'b0, A_OUT, 32'h0});
        exp_res = tmo ? 32'hDEADBEEF : ov;
        exp_err = tmo;
        exp_len = len;
        busy_left = busy;
        out_val = ov;
        wait_max = waits;
        wait_rand = wrand;
        din_gap = gap;
        din_gap_rand = grand;
        n_status = 0; n_output = 0; n_input = 0;
        n_din_xfer = 0; n_din_ready_cyc = 0;
        @(negedge CLK);
        ifc.job_config = cfg;
        ifc.job_len = 8'(len);
        ifc.job_start = 1'b1;
        @(negedge CLK);
        ifc.job_start = 1'b0;
        ifc.job_config = $urandom;
        ifc.job_len = 8'($urandom);
        chk(ifc.job_busy == 1'b1, "busy_on_start", 32'(ifc.job_busy), 32'h1);
    endtask

    task automatic finish_job(input int hold);
        int          t;
        logic [31:0] r0;
        t = 0;
        ifc.result_ready = 1'b0;
        while (!ifc.result_valid && t < 4000) begin
            ifc.job_start = ($urandom_range(0, 3) == 0);
            @(negedge CLK);
            t++;
        end
        ifc.job_start = 1'b0;
        if (!ifc.result_valid) begin
            chk(1'b0, "result_wait_timeout", 32'(t), 32'd4000);
            do_reset();
            return;
        end
        chk(ifc.result == exp_res, "result", ifc.result, exp_res);
        chk(ifc.result_err == exp_err, "result_err", 32'(ifc.result_err), 32'(exp_err));
        last_result = ifc.result;
        last_err = ifc.result_err;
        r0 = ifc.result;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk(ifc.result_valid == 1'b1 && ifc.result == r0, "result_hold", ifc.result, r0);
        end
        ifc.result_ready = 1'b1;
        @(negedge CLK);
        ifc.result_ready = 1'b0;
        chk(ifc.result_valid == 1'b0, "valid_drop", 32'(ifc.result_valid), 32'h0);
        chk(ifc.job_busy == 1'b0, "busy_drop", 32'(ifc.job_busy), 32'h0);
        chk(exp_q.size() == 0, "bus_txn_missing", 32'(exp_q.size()), 32'h0);
        chk(n_din_xfer == exp_len, "din_count", 32'(n_din_xfer), 32'(exp_len));
        if (exp_len == 0)
            chk(n_din_ready_cyc == 0, "din_ready_len0", 32'(n_din_ready_cyc), 32'h0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        din_q.delete();
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic chk_trace_basic(input string tag);
        txn_t lit[6];
        lit[0] = '{1'b1, 32'h00ff001C, 32'h04C11DB7};
        lit[1] = '{1'b1, 32'h00ff0018, 32'h00000001};
        lit[2] = '{1'b1, 32'h00ff0024, 32'h00000011};
        lit[3] = '{1'b1, 32'h00ff0024, 32'h00000022};
        lit[4] = '{1'b0, 32'h00ff0020, 32'h00000000};
        lit[5] = '{1'b0, 32'h00ff0028, 32'h00000000};
        chk(trace.size() == 6, {tag, "_len"}, 32'(trace.size()), 32'd6);
        for (int i = 0; i < 6 && i < trace.size(); i++)
            chk(trace[i] == lit[i], tag, trace[i].addr ^ trace[i].data, lit[i].addr ^ lit[i].data);
    endtask

    initial begin
        int t;
        ifc.job_start = 1'b0;
        ifc.job_config = 32'h0;
        ifc.job_len = 8'h0;
        ifc.result_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk({ifc.bus_req, ifc.bus_wen, ifc.din_ready, ifc.job_busy, ifc.result_err, ifc.result_valid} == 6'b0,
            "reset_flags", 32'({ifc.bus_req, ifc.bus_wen, ifc.din_ready, ifc.job_busy, ifc.result_err, ifc.result_valid}), 32'h0);
        chk((ifc.bus_addr | ifc.bus_wdata | ifc.result) == 32'h0, "reset_data",
            ifc.bus_addr | ifc.bus_wdata | ifc.result, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);

        // bus_ready pulses while idle must be ignored
        spurious = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk(ifc.bus_req == 1'b0 && ifc.job_busy == 1'b0, "spurious_ready",
                32'({ifc.bus_req, ifc.job_busy}), 32'h0);
        end
        spurious = 1'b0;
        repeat (2) @(negedge CLK);

        // two words, zero-wait responder, status idle on first read
        next_words.push_back(32'h11);
        next_words.push_back(32'h22);
        start_job(32'h04C11DB7, 2, 0, 0, 1'b0, 0, 1'b0, 32'hCAFE0031);
        finish_job(0);
        chk_trace_basic("trace_basic");
        chk(last_result == 32'hCAFE0031, "basic_result_lit", last_result, 32'hCAFE0031);

        // zero-length job
        start_job(32'h12345678, 0, 0, 1, 1'b0, 0, 1'b0, 32'h0BAD_F00D);
        finish_job(1);
        chk(n_input == 0, "len0_no_input", 32'(n_input), 32'h0);

        // three wait states per access and two-cycle din gaps
        next_words.push_back(32'h11);
        next_words.push_back(32'h22);
        start_job(32'h04C11DB7, 2, 0, 3, 1'b0, 2, 1'b0, 32'h5555_AAAA);
        finish_job(0);
        chk_trace_basic("trace_waits");

        // busy for five status reads, result_ready withheld for four cycles
        start_job(32'hA5A5_0001, 3, 5, 1, 1'b1, 1, 1'b1, 32'h1357_9BDF);
        finish_job(4);
        chk(n_status == 6, "busy5_status_reads", 32'(n_status), 32'd6);
        chk(n_output == 1, "busy5_output_reads", 32'(n_output), 32'd1);

`ifdef POLI_CRC_TIMEOUT_EN
        start_job(32'h0000_00FF, 1, 1000, 0, 1'b0, 0, 1'b0, 32'h2468_ACE0);
        finish_job(2);
        chk(n_status == 4, "tmo_status_reads", 32'(n_status), 32'd4);
        chk(n_output == 0, "tmo_no_output", 32'(n_output), 32'd0);
        chk(last_result == 32'hDEADBEEF && last_err == 1'b1, "tmo_result_lit", last_result, 32'hDEADBEEF);
`endif

        // reset while a CRC_INPUT write is waiting for the responder
        start_job(32'hFEED_0002, 2, 0, 3, 1'b0, 0, 1'b0, 32'h7777_0000);
        t = 0;
        while (!(ifc.bus_req && ifc.bus_wen && ifc.bus_addr == A_IN) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        chk(t < 500, "reach_wr_din", 32'(t), 32'd500);
        #2 nRST = 1'b0;
        #1;
        chk({ifc.bus_req, ifc.bus_wen, ifc.din_ready, ifc.job_busy, ifc.result_err, ifc.result_valid} == 6'b0,
            "async_reset_flags", 32'({ifc.bus_req, ifc.bus_wen, ifc.din_ready, ifc.job_busy, ifc.result_err, ifc.result_valid}), 32'h0);
        chk((ifc.bus_addr | ifc.bus_wdata | ifc.result) == 32'h0, "async_reset_data",
            ifc.bus_addr | ifc.bus_wdata | ifc.result, 32'h0);
        repeat (2) @(negedge CLK);
        exp_q.delete();
        din_q.delete();
        nRST = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            chk(ifc.bus_req == 1'b0 && ifc.job_busy == 1'b0, "idle_after_reset",
                32'({ifc.bus_req, ifc.job_busy}), 32'h0);
        end
        start_job(32'hC0DE_0003, 2, 1, 2, 1'b1, 2, 1'b1, 32'h9999_1111);
        finish_job(1);

        for (int j = 0; j < 12; j++) begin
            start_job($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                      3, 1'b1, 2, 1'b1, $urandom);
            finish_job(int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
